// File: rtl/image_bank_reader_if.sv
// Pixel-group stream from the bank reader to the conv engine.
// Master drives data/valid/last, slave returns ready.
interface image_bank_reader_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/image_bank_reader.sv
// Read-side master for the four 8-bit image banks: walks an address range,
// absorbs the bank read latency in a small FIFO and streams 32-bit groups.
module image_bank_reader #(
    parameter int ADDR_W     = 14,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [7:0]        read0,
    input  logic [7:0]        read1,
    input  logic [7:0]        read2,
    input  logic [7:0]        read3,
    image_bank_reader_if.master out_if
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0]   rd_last_q, rd_last_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [32:0]         mem_q [FIFO_DEPTH];

    logic                issue;
    logic                issue_last;
    logic                push;
    logic                pop;
    logic                fifo_nonempty;
    logic [OCC_W-1:0]    occ;

    function automatic logic [OCC_W-1:0] popcnt(input logic [RD_LAT-1:0] v);
        logic [OCC_W-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LAT; i++) n = n + {{(OCC_W-1){1'b0}}, v[i]};
        return n;
    endfunction

    assign fifo_nonempty = (count_q != '0);
    assign push          = rd_vld_q[RD_LAT-1];
    assign pop           = fifo_nonempty && out_if.out_ready;
    // Reads already in the bank pipe count against FIFO space so nothing can overflow.
    assign occ           = {1'b0, count_q} + popcnt(rd_vld_q);

    always_comb begin
        state_d     = state_q;
        addr_cnt_d  = addr_cnt_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = RUN;
                        addr_cnt_d  = base_addr;
                        remaining_d = len;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if ((remaining_q != '0) && (occ < DEPTH_OCC)) begin
                    issue       = 1'b1;
                    addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
                    if (remaining_q == (ADDR_W+1)'(1)) begin
                        issue_last = 1'b1;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && mem_q[rd_ptr_q][32]) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_vld_d     = rd_vld_q;
        rd_last_d    = rd_last_q;
        rd_vld_d[0]  = issue;
        rd_last_d[0] = issue_last;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_vld_d[i]  = rd_vld_q[i-1];
            rd_last_d[i] = rd_last_q[i-1];
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_cnt_q  <= '0;
            remaining_q <= '0;
            rd_vld_q    <= '0;
            rd_last_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_cnt_q  <= addr_cnt_d;
            remaining_q <= remaining_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Bank q is valid exactly when the pipe tail is set, so capture it then.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {rd_last_q[RD_LAT-1], read3, read2, read1, read0};
    end

    assign ram_rden         = issue;
    assign ram_addr         = addr_cnt_q;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign out_if.out_valid = fifo_nonempty;
    assign out_if.out_data  = fifo_nonempty ? mem_q[rd_ptr_q][31:0] : 32'h0;
    assign out_if.out_last  = fifo_nonempty ? mem_q[rd_ptr_q][32] : 1'b0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && (count_q == DEPTH_CNT)));

endmodule
